// File: rtl/buffered_spike_router_pkg.sv
// Shared types and constants for the buffered spike router.
// Address 0 is reserved as "no connection" in the translation table.
package spike_router_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 8;
   localparam int NO_CONNECTION      = 0;

   typedef struct packed {
      logic                          on_off;
      logic [DEFAULT_ADDR_WIDTH-1:0] address;
   } spike_event_t;

   // A single-column router still needs a 1-bit pointer to stay legal.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/buffered_spike_router_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, with wrap.
// The pointer register is owned by the parent.
module rr_arbiter
   import spike_router_pkg::*;
#(
   parameter  int N  = 1,
   localparam int PW = ptr_width(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] gnt_idx_o,
   output logic          gnt_any_o
);

   logic [PW-1:0] cand_s;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= 32'(N)) begin
         sum = sum - 32'(N);
      end else begin
         sum = sum;
      end
      return PW'(sum);
   endfunction

   // Scan from the pointer upward and latch onto the first request seen.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      cand_s    = '0;
      for (int off = 0; off < N; off++) begin
         cand_s = wrap_add(ptr_i, 32'(off));
         if (!gnt_any_o && req_i[cand_s]) begin
            gnt_o[cand_s] = 1'b1;
            gnt_idx_o     = cand_s;
            gnt_any_o     = 1'b1;
         end else begin
            gnt_any_o = gnt_any_o;
         end
      end
   end

endmodule

// File: rtl/buffered_spike_router.sv
// Routes column spikes through a per-row translation table into per-row pending sets,
// serialising collisions with a round-robin arbiter; external stimulus wins at the output.
module buffered_spike_router
   import spike_router_pkg::*;
#(
   parameter int NUM_COLS         = 1,
   parameter int NUM_SYNAPSE_ROWS = 1,
   parameter int ADDR_WIDTH       = 8,
   parameter int DROP_CNT_WIDTH   = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      col_valid   [NUM_COLS],
   input  logic                      col_on_off  [NUM_COLS],
   input  logic [ADDR_WIDTH-1:0]     connections [NUM_SYNAPSE_ROWS][NUM_COLS],
   input  logic                      ext_valid   [NUM_SYNAPSE_ROWS],
   input  logic                      ext_on_off  [NUM_SYNAPSE_ROWS],
   input  logic [ADDR_WIDTH-1:0]     ext_address [NUM_SYNAPSE_ROWS],
   output logic                      out_valid   [NUM_SYNAPSE_ROWS],
   output logic                      out_on_off  [NUM_SYNAPSE_ROWS],
   output logic [ADDR_WIDTH-1:0]     out_address [NUM_SYNAPSE_ROWS],
   output logic                      pending_any [NUM_SYNAPSE_ROWS],
   output logic [DROP_CNT_WIDTH-1:0] drop_count  [NUM_SYNAPSE_ROWS],
   input  logic                      clear_drops
);

   localparam int PW = ptr_width(NUM_COLS);

   typedef struct packed {
      logic                  on_off;
      logic [ADDR_WIDTH-1:0] address;
   } row_event_t;

   logic [NUM_COLS-1:0]       pend_q      [NUM_SYNAPSE_ROWS];
   logic [NUM_COLS-1:0]       pend_d      [NUM_SYNAPSE_ROWS];
   row_event_t                evt_q       [NUM_SYNAPSE_ROWS][NUM_COLS];
   row_event_t                evt_d       [NUM_SYNAPSE_ROWS][NUM_COLS];
   logic [PW-1:0]             rr_ptr_q    [NUM_SYNAPSE_ROWS];
   logic [PW-1:0]             rr_ptr_d    [NUM_SYNAPSE_ROWS];
   logic                      out_valid_q [NUM_SYNAPSE_ROWS];
   logic                      out_valid_d [NUM_SYNAPSE_ROWS];
   row_event_t                out_evt_q   [NUM_SYNAPSE_ROWS];
   row_event_t                out_evt_d   [NUM_SYNAPSE_ROWS];
   logic [DROP_CNT_WIDTH-1:0] drop_q      [NUM_SYNAPSE_ROWS];
   logic [DROP_CNT_WIDTH-1:0] drop_d      [NUM_SYNAPSE_ROWS];
   logic [NUM_COLS-1:0]       gnt_s       [NUM_SYNAPSE_ROWS];
   logic [PW-1:0]             gnt_idx_s   [NUM_SYNAPSE_ROWS];
   logic                      gnt_any_s   [NUM_SYNAPSE_ROWS];
   logic [NUM_COLS-1:0]       pop_s       [NUM_SYNAPSE_ROWS];

   for (genvar r = 0; r < NUM_SYNAPSE_ROWS; r++) begin : g_row
      rr_arbiter #(.N(NUM_COLS)) u_arb (
         .req_i     (pend_q[r]),
         .ptr_i     (rr_ptr_q[r]),
         .gnt_o     (gnt_s[r]),
         .gnt_idx_o (gnt_idx_s[r]),
         .gnt_any_o (gnt_any_s[r])
      );

      assign out_valid[r]   = out_valid_q[r];
      assign out_on_off[r]  = out_evt_q[r].on_off;
      assign out_address[r] = out_evt_q[r].address;
      assign pending_any[r] = |pend_q[r];
      assign drop_count[r]  = drop_q[r];
   end

   // Output select and pop first, then capture, so a same-cycle re-fire on the popped column re-arms it.
   always_comb begin
      pend_d      = pend_q;
      evt_d       = evt_q;
      rr_ptr_d    = rr_ptr_q;
      out_valid_d = out_valid_q;
      out_evt_d   = out_evt_q;
      drop_d      = drop_q;
      for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
         pop_s[r] = '0;
         if (ext_valid[r]) begin
            out_valid_d[r] = 1'b1;
            out_evt_d[r]   = '{on_off: ext_on_off[r], address: ext_address[r]};
         end else if (gnt_any_s[r]) begin
            out_valid_d[r] = 1'b1;
            out_evt_d[r]   = evt_q[r][gnt_idx_s[r]];
            pop_s[r]       = gnt_s[r];
            pend_d[r]      = pend_q[r] & ~gnt_s[r];
            rr_ptr_d[r]    = (gnt_idx_s[r] == PW'(NUM_COLS - 1)) ? '0 : gnt_idx_s[r] + PW'(1);
         end else begin
            out_valid_d[r] = 1'b0;
         end

         for (int c = 0; c < NUM_COLS; c++) begin
            if (col_valid[c] && (connections[r][c] != ADDR_WIDTH'(NO_CONNECTION))) begin
               if (pend_q[r][c] && !pop_s[r][c]) begin
                  if (drop_d[r] != '1) begin
                     drop_d[r] = drop_d[r] + DROP_CNT_WIDTH'(1);
                  end else begin
                     drop_d[r] = drop_d[r];
                  end
               end else begin
                  pend_d[r][c] = 1'b1;
                  evt_d[r][c]  = '{on_off: col_on_off[c], address: connections[r][c]};
               end
            end else begin
               pend_d[r][c] = pend_d[r][c];
            end
         end

         if (clear_drops) begin
            drop_d[r] = '0;
         end else begin
            drop_d[r] = drop_d[r];
         end
      end
   end

   // State registers; reset discards every pending event.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
            pend_q[r]      <= '0;
            rr_ptr_q[r]    <= '0;
            out_valid_q[r] <= 1'b0;
            out_evt_q[r]   <= '0;
            drop_q[r]      <= '0;
            for (int c = 0; c < NUM_COLS; c++) begin
               evt_q[r][c] <= '0;
            end
         end
      end else begin
         pend_q      <= pend_d;
         evt_q       <= evt_d;
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_evt_q   <= out_evt_d;
         drop_q      <= drop_d;
      end
   end

endmodule

// File: doc/buffered_spike_router.md
# buffered_spike_router

Parametrised successor to the combinational feedback/stimulus merger between the neuron columns and the synapse-row drivers. Column output spikes are translated per synapse row through the connection table and held in a per-row pending set, so same-cycle collisions from several columns are serialised instead of lost. External stimulus has priority at the row output. Events are dropped only when a column re-fires before its previous event to that row has been delivered; each drop is counted.

## Interface
Parameters:
- NUM_COLS, 1, number of neuron columns feeding spikes
- NUM_SYNAPSE_ROWS, 1, number of synapse-row outputs
- ADDR_WIDTH, 8, synapse address width; address 0 means "no connection"
- DROP_CNT_WIDTH, 16, width of the per-row saturating drop counter

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- col_valid[NUM_COLS]  in  1  column spike strobe
- col_on_off[NUM_COLS]  in  1  column spike polarity
- connections[NUM_SYNAPSE_ROWS][NUM_COLS]  in  ADDR_WIDTH  per-row translation table
- ext_valid[NUM_SYNAPSE_ROWS]  in  1  external stimulus strobe
- ext_on_off[NUM_SYNAPSE_ROWS]  in  1  external polarity
- ext_address[NUM_SYNAPSE_ROWS]  in  ADDR_WIDTH  external address
- out_valid[NUM_SYNAPSE_ROWS]  out  1  row spike strobe (registered)
- out_on_off[NUM_SYNAPSE_ROWS]  out  1  row spike polarity
- out_address[NUM_SYNAPSE_ROWS]  out  ADDR_WIDTH  row spike address
- pending_any[NUM_SYNAPSE_ROWS]  out  1  row has undelivered feedback events
- drop_count[NUM_SYNAPSE_ROWS]  out  DROP_CNT_WIDTH  saturating dropped-event count
- clear_drops  in  1  synchronous clear of all drop counters

## Operation
- Per row r, per column c: pending bit p[r][c] plus stored event {on_off, address}. The address is captured at set time, so later table changes do not alter pending events.
- Capture: if col_valid[c] and connections[r][c] != 0:
  - p[r][c] is set and the event is stored.
  - If p[r][c] is already set and not popped this cycle, the new event is dropped, the stored event is kept, and drop_count[r] increments (saturating at all-ones).
- Pop and capture on the same column in the same cycle: the popped event is delivered, p stays set, and the new event is stored. This is not a drop.
- Output selection, per row, each cycle:
  - If ext_valid[r]: register the external event. No pop; the round-robin pointer is unchanged.
  - Else if any p[r][*]: the round-robin arbiter grants the first set bit searching from rr_ptr[r] upward, with wrap. The granted event is registered and p cleared, and rr_ptr[r] becomes (grant+1) mod NUM_COLS.
  - Else: out_valid = 0. out_on_off and out_address hold their previous values.
- pending_any[r] = OR of p[r][*], taken combinationally from the registers.
- clear_drops has priority over increment in the same cycle.

## Timing
- Reset values:
  - out_valid, out_on_off, out_address, p, stored events: 0
  - rr_ptr: 0
  - drop_count: 0
  - pending_any: 0
- External latency: ext_valid in cycle n gives out_valid in cycle n+1.
- Feedback latency: col_valid in cycle n sets p at the end of n, is eligible in n+1, and appears at out_valid in n+2 at the earliest.
- Throughput: one event per row per cycle. K simultaneous column spikes to one row drain over K consecutive cycles when there is no external traffic.
- Continuous ext_valid stalls feedback indefinitely. Pending bits persist, and re-fires during the stall count as drops.
- Reset asserted mid-operation clears all pending events immediately, with no output on deassertion.

## Structure
- Package spike_router_pkg:
  - typedef spike_event_t {logic on_off; logic [ADDR_WIDTH-1:0] address;}, parameterised through a package-level default
  - localparam NO_CONNECTION = 0
- Sub-module rr_arbiter #(N), one instance per row:
  - inputs: request vector, pointer
  - outputs: grant one-hot, grant index, any-grant
  - purely combinational; the pointer register lives in the parent

## Test plan
- Basic feedback: NUM_COLS=4, connections[0][2]=5, col_valid[2]=1 with on_off=1 in cycle 0 -> out_valid[0]=1, address 5, on_off 1 in cycle 2 only.
- Collision: cols 0, 1, 3 fire in one cycle, all mapped to row 0 (addresses 1, 2, 4) -> outputs 1, 2, 4 on three consecutive cycles, drop_count 0.
- Priority: ext_valid[0] held for 3 cycles while col 1 is pending -> 3 external events, then the col 1 event on the 4th cycle; rr_ptr unchanged during the stall.
- Drop: col 0 fires twice while row 0 is blocked by ext_valid -> one delivered event carrying the first on_off, drop_count[0]=1; clear_drops -> 0. Saturation: preload via repeated drops with DROP_CNT_WIDTH=2 -> holds at 3.
- Zero-address and table change: connections[1][0]=0, col 0 fires -> no row 1 output. Set connections[0][0]=7, fire col 0, then change the entry to 9 -> delivered address 7.
- Reset mid-drain: 3 pending events, assert reset_n low for 1 cycle -> all outputs 0, pending_any 0, no events after release.
